// File: rtl/uart_pkg.sv
// Shared definitions for the UART command receiver: default baud divisor,
// receive FSM states and the frame data length.
package uart_pkg;

   localparam int unsigned BAUD_DIV_DEF = 2604;
   localparam int unsigned FRAME_BITS   = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      DATA     = 3'd2,
      STOP     = 3'd3,
      BRK_WAIT = 3'd4
   } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input; the reset level is
// a parameter so an idle-high line does not glitch on reset release.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic q_r;

   // Metastability-settling chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= RST_VAL;
         q_r    <= RST_VAL;
      end else begin
         meta_r <= d;
         q_r    <= meta_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver for the BLE command link: mid-bit sampling from a
// down-counting baud timer, sticky framing/overrun flags, consumer handshake.
module uart_cmd_rx
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frm_err,
   output logic       ovr_err
);

   localparam logic [11:0] DIV_FULL = 12'(BAUD_DIV);
   localparam logic [11:0] DIV_HALF = 12'(BAUD_DIV / 2);
   localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 1);

   rx_state_e   state_r, state_nxt_s;
   logic [11:0] cnt_r, cnt_nxt_s;
   logic [3:0]  bit_cnt_r, bit_cnt_nxt_s;
   logic [7:0]  shift_r, shift_nxt_s;
   logic [7:0]  rx_data_r, rx_data_nxt_s;
   logic        rdy_r, rdy_nxt_s;
   logic        frm_err_r, frm_err_nxt_s;
   logic        ovr_err_r, ovr_err_nxt_s;
   logic        rx_s;
   logic        expire_s;

   sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (RX),
      .q     (rx_s)
   );

   // The count reaching zero is the expiry event; a reload replaces the zero.
   assign expire_s = (cnt_r <= 12'd1);

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= 12'd0;
         bit_cnt_r <= 4'd0;
         shift_r   <= 8'h00;
         rx_data_r <= 8'h00;
         rdy_r     <= 1'b0;
         frm_err_r <= 1'b0;
         ovr_err_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         shift_r   <= shift_nxt_s;
         rx_data_r <= rx_data_nxt_s;
         rdy_r     <= rdy_nxt_s;
         frm_err_r <= frm_err_nxt_s;
         ovr_err_r <= ovr_err_nxt_s;
      end
   end

   // Next-state, baud timing and flag update logic.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      bit_cnt_nxt_s = bit_cnt_r;
      shift_nxt_s   = shift_r;
      rx_data_nxt_s = rx_data_r;
      rdy_nxt_s     = rdy_r & ~clr_rdy;
      frm_err_nxt_s = frm_err_r & ~clr_rdy;
      ovr_err_nxt_s = ovr_err_r & ~clr_rdy;
      case (state_r)
         IDLE: begin
            if (!rx_s) begin
               state_nxt_s = START;
               cnt_nxt_s   = DIV_HALF;
            end else begin
               cnt_nxt_s   = 12'd0;
            end
         end
         START: begin
            if (!expire_s) begin
               cnt_nxt_s = cnt_r - 12'd1;
            end else if (rx_s) begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = 12'd0;
            end else begin
               state_nxt_s   = DATA;
               cnt_nxt_s     = DIV_FULL;
               bit_cnt_nxt_s = 4'd0;
            end
         end
         DATA: begin
            if (expire_s) begin
               shift_nxt_s   = {rx_s, shift_r[7:1]};
               bit_cnt_nxt_s = bit_cnt_r + 4'd1;
               cnt_nxt_s     = DIV_FULL;
               if (bit_cnt_r == LAST_BIT) begin
                  state_nxt_s = STOP;
               end else begin
                  state_nxt_s = DATA;
               end
            end else begin
               cnt_nxt_s = cnt_r - 12'd1;
            end
         end
         STOP: begin
            if (!expire_s) begin
               cnt_nxt_s = cnt_r - 12'd1;
            end else if (rx_s) begin
               // Good byte: rdy set wins over clr_rdy, the error flags do not.
               state_nxt_s   = IDLE;
               cnt_nxt_s     = 12'd0;
               rx_data_nxt_s = shift_r;
               rdy_nxt_s     = 1'b1;
               ovr_err_nxt_s = ~clr_rdy & (ovr_err_r | rdy_r);
            end else begin
               state_nxt_s   = BRK_WAIT;
               cnt_nxt_s     = 12'd0;
               frm_err_nxt_s = 1'b1;
            end
         end
         BRK_WAIT: begin
            if (rx_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = BRK_WAIT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 12'd0;
         end
      endcase
   end

   assign rx_data = rx_data_r;
   assign rdy     = rdy_r;
   assign frm_err = frm_err_r;
   assign ovr_err = ovr_err_r;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx at BAUD_DIV = 16: table-driven byte
// vectors plus hand-written corner sequences, with a received-byte scoreboard.
module tb_uart_cmd_rx;

   localparam int BD = 16;

   typedef struct {
      logic [7:0] data;
      logic       clr_after;
      logic       exp_rdy;
      logic       exp_ovr;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       RX = 1'b1;
   logic       clr_rdy = 1'b0;
   logic [7:0] rx_data;
   logic       rdy;
   logic       frm_err;
   logic       ovr_err;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] prev_data;
   logic       prev_rdy;
   vec_t       vecs[5];

   always #5 clk = ~clk;

   uart_cmd_rx #(.BAUD_DIV(BD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .RX      (RX),
      .clr_rdy (clr_rdy),
      .rx_data (rx_data),
      .rdy     (rdy),
      .frm_err (frm_err),
      .ovr_err (ovr_err)
   );

   task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // UART transmit model; called and returns on a falling clock edge.
   task automatic send_byte(input logic [7:0] b, input logic stop_v, input int stop_len);
      RX = 1'b0;
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (BD) @(negedge clk);
      end
      RX = stop_v;
      repeat (stop_len) @(negedge clk);
      RX = 1'b1;
   endtask

   task automatic pulse_clr();
      clr_rdy = 1'b1;
      @(negedge clk);
      clr_rdy = 1'b0;
   endtask

   // Scoreboard: a new byte shows up as rdy rising or rx_data changing.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_data = 8'h00;
         prev_rdy  = 1'b0;
      end else begin
         if ((rdy && !prev_rdy) || (rx_data !== prev_data)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb_unexpected: got byte %02h expected none", rx_data);
            end else begin
               check_byte("sb_rx_data", rx_data, exp_q.pop_front());
            end
         end
         prev_data = rx_data;
         prev_rdy  = rdy;
      end
   end

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{8'h67, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'h73, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{8'h11, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'h22, 1'b1, 1'b1, 1'b1};

      repeat (3) @(negedge clk);
      check_byte("rst_rx_data", rx_data, 8'h00);
      check_bit("rst_rdy", rdy, 1'b0);
      check_bit("rst_frm_err", frm_err, 1'b0);
      check_bit("rst_ovr_err", ovr_err, 1'b0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(vecs[i].data);
         send_byte(vecs[i].data, 1'b1, BD);
         repeat (2) @(negedge clk);
         check_bit($sformatf("vec%0d_rdy", i), rdy, vecs[i].exp_rdy);
         check_bit($sformatf("vec%0d_ovr_err", i), ovr_err, vecs[i].exp_ovr);
         check_bit($sformatf("vec%0d_frm_err", i), frm_err, 1'b0);
         if (vecs[i].clr_after) begin
            pulse_clr();
            check_bit($sformatf("vec%0d_clr_rdy", i), rdy, 1'b0);
            check_bit($sformatf("vec%0d_clr_ovr", i), ovr_err, 1'b0);
         end
      end

      // Glitch shorter than half a bit is rejected as a false start.
      RX = 1'b0;
      repeat (4) @(negedge clk);
      RX = 1'b1;
      repeat (40) @(negedge clk);
      check_bit("glitch_rdy", rdy, 1'b0);
      check_bit("glitch_frm_err", frm_err, 1'b0);
      check_byte("glitch_rx_data", rx_data, 8'h22);

      // Stop bit held low for 40 clocks: framing error, then a clean byte.
      send_byte(8'h3C, 1'b0, 40);
      check_bit("brk_frm_err", frm_err, 1'b1);
      check_bit("brk_rdy", rdy, 1'b0);
      check_byte("brk_rx_data", rx_data, 8'h22);
      repeat (4) @(negedge clk);
      exp_q.push_back(8'h5A);
      send_byte(8'h5A, 1'b1, BD);
      repeat (2) @(negedge clk);
      check_bit("after_brk_rdy", rdy, 1'b1);
      check_bit("after_brk_frm_sticky", frm_err, 1'b1);
      check_bit("after_brk_ovr_err", ovr_err, 1'b0);

      // Reset pulse during data bit 4 of 8'hFF abandons the frame.
      fork
         send_byte(8'hFF, 1'b1, BD);
         begin
            repeat (88) @(posedge clk);
            #2 rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b1;
         end
      join
      repeat (2) @(negedge clk);
      check_byte("midrst_rx_data", rx_data, 8'h00);
      check_bit("midrst_rdy", rdy, 1'b0);
      check_bit("midrst_frm_err", frm_err, 1'b0);
      check_bit("midrst_ovr_err", ovr_err, 1'b0);
      exp_q.push_back(8'h81);
      send_byte(8'h81, 1'b1, BD);
      repeat (2) @(negedge clk);
      check_bit("post_rst_rdy", rdy, 1'b1);
      check_bit("post_rst_ovr_err", ovr_err, 1'b0);

      // clr_rdy lands in the completion cycle of 8'h42 while rdy is still set.
      repeat (4) @(negedge clk);
      exp_q.push_back(8'h42);
      fork
         send_byte(8'h42, 1'b1, BD);
         begin
            repeat (154) @(negedge clk);
            clr_rdy = 1'b1;
            @(negedge clk);
            clr_rdy = 1'b0;
         end
      join
      repeat (2) @(negedge clk);
      check_bit("coinc_rdy", rdy, 1'b1);
      check_byte("coinc_rx_data", rx_data, 8'h42);
      check_bit("coinc_ovr_err", ovr_err, 1'b0);
      check_bit("coinc_frm_err", frm_err, 1'b0);

      repeat (4) @(negedge clk);
      check_byte("sb_drained", 8'(exp_q.size()), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
